// File: rtl/ballot_unit_ctrl.sv
// Ballot unit front end: conditions the push-buttons, issues one ballot per release and emits clean vote pulses.
// Optional audit counters are enabled with the BALLOT_AUDIT_EN macro.
module ballot_unit_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_WIDTH        = 5,
  parameter int ARM_TIMEOUT     = 100,
  parameter int BUZZ_CYCLES     = 8,
  parameter int WIDTH           = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_on_evm,
  input  logic voting_in_progress,
  input  logic btn_release_raw,
  input  logic btn_c1_raw,
  input  logic btn_c2_raw,
  input  logic btn_c3_raw,
  output logic candidate_ready,
  output logic vote_candidate_1,
  output logic vote_candidate_2,
  output logic vote_candidate_3,
  output logic ballot_lamp,
  output logic buzzer,
  output logic multi_press_err
`ifdef BALLOT_AUDIT_EN
  ,
  output logic [WIDTH-1:0] audit_ballots_issued,
  output logic [WIDTH-1:0] audit_votes_cast
`endif
);

  localparam int TMR_MAX = (ARM_TIMEOUT > BUZZ_CYCLES) ? ARM_TIMEOUT : BUZZ_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_LOCKED, S_ARM, S_OPEN, S_VOTE, S_BEEP, S_WAIT_REL
  } state_t;

  // Channel 0 is the release button, channels 1..3 are the candidates.
  logic [3:0]          raw;
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          db_q, db_d, dbp_q, rise_q;
  logic [DB_WIDTH-1:0] cnt_q [4];
  logic [DB_WIDTH-1:0] cnt_d [4];

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [2:0]          sel_q, sel_d;
  logic [2:0]          cand_lvls;
  logic                err_d;

  logic                cand_q, lamp_q, buzz_q, err_q;
  logic [2:0]          vote_q;

  assign raw = {btn_c3_raw, btn_c2_raw, btn_c1_raw, btn_release_raw};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      rise_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      rise_q  <= db_q & ~dbp_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cand_lvls = db_q[3:1];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      S_LOCKED: begin
        tmr_d = '0;
        if (rise_q[0]) state_d = S_ARM;
      end
      S_ARM: begin
        if (voting_in_progress) begin
          state_d = S_OPEN;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(ARM_TIMEOUT - 1)) begin
          state_d = S_LOCKED;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OPEN: begin
        // Loss of the evm handshake wins over a button edge in the same cycle.
        if (!voting_in_progress) begin
          state_d = S_LOCKED;
        end else if (|rise_q[3:1]) begin
          if ($onehot(cand_lvls)) begin
            state_d = S_VOTE;
            sel_d   = cand_lvls;
          end else if ($countones(cand_lvls) >= 2) begin
            err_d = 1'b1;
          end
        end
      end
      S_VOTE: begin
        state_d = S_BEEP;
        tmr_d   = '0;
      end
      S_BEEP: begin
        if (tmr_q == TMR_W'(BUZZ_CYCLES - 1)) begin
          state_d = S_WAIT_REL;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (cand_lvls == 3'b000) state_d = S_LOCKED;
      end
      default: state_d = S_LOCKED;
    endcase
    if (!switch_on_evm) begin
      state_d = S_LOCKED;
      tmr_d   = '0;
      err_d   = 1'b0;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOCKED;
      tmr_q   <= '0;
      sel_q   <= '0;
      cand_q  <= 1'b0;
      lamp_q  <= 1'b0;
      buzz_q  <= 1'b0;
      err_q   <= 1'b0;
      vote_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sel_q   <= sel_d;
      cand_q  <= (state_d == S_ARM);
      lamp_q  <= (state_d == S_OPEN) || (state_d == S_VOTE);
      buzz_q  <= (state_d == S_BEEP);
      err_q   <= err_d;
      vote_q  <= (state_d == S_VOTE) ? sel_d : 3'b000;
    end
  end

  assign candidate_ready  = cand_q;
  assign ballot_lamp      = lamp_q;
  assign buzzer           = buzz_q;
  assign multi_press_err  = err_q;
  assign vote_candidate_1 = vote_q[0];
  assign vote_candidate_2 = vote_q[1];
  assign vote_candidate_3 = vote_q[2];

`ifdef BALLOT_AUDIT_EN
  logic [WIDTH-1:0] issued_q, issued_d, cast_q, cast_d;

  always_comb begin
    issued_d = issued_q;
    cast_d   = cast_q;
    if (!switch_on_evm) begin
      issued_d = '0;
      cast_d   = '0;
    end else begin
      if (state_q == S_ARM && state_d == S_OPEN && !(&issued_q)) issued_d = issued_q + 1'b1;
      if (state_q == S_VOTE && !(&cast_q)) cast_d = cast_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      cast_q   <= '0;
    end else begin
      issued_q <= issued_d;
      cast_q   <= cast_d;
    end
  end

  assign audit_ballots_issued = issued_q;
  assign audit_votes_cast     = cast_q;
`endif

endmodule

// File: tb/tb_ballot_unit_ctrl.sv
// Directed bench for ballot_unit_ctrl; builds with or without BALLOT_AUDIT_EN.
module tb_ballot_unit_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic switch_on_evm = 1'b1;
  logic voting_in_progress = 1'b0;
  logic btn_release_raw = 1'b0;
  logic btn_c1_raw = 1'b0;
  logic btn_c2_raw = 1'b0;
  logic btn_c3_raw = 1'b0;
  logic candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic ballot_lamp, buzzer, multi_press_err;
`ifdef BALLOT_AUDIT_EN
  logic [6:0] audit_ballots_issued, audit_votes_cast;
`endif

  int checks = 0;
  int errors = 0;
  int v1n = 0, v2n = 0, v3n = 0, errn = 0;
  logic dual_vote = 1'b0;

  ballot_unit_ctrl dut (
    .clk(clk), .rst(rst), .switch_on_evm(switch_on_evm),
    .voting_in_progress(voting_in_progress), .btn_release_raw(btn_release_raw),
    .btn_c1_raw(btn_c1_raw), .btn_c2_raw(btn_c2_raw), .btn_c3_raw(btn_c3_raw),
    .candidate_ready(candidate_ready), .vote_candidate_1(vote_candidate_1),
    .vote_candidate_2(vote_candidate_2), .vote_candidate_3(vote_candidate_3),
    .ballot_lamp(ballot_lamp), .buzzer(buzzer), .multi_press_err(multi_press_err)
`ifdef BALLOT_AUDIT_EN
    , .audit_ballots_issued(audit_ballots_issued), .audit_votes_cast(audit_votes_cast)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vote_candidate_1) v1n++;
    if (vote_candidate_2) v2n++;
    if (vote_candidate_3) v3n++;
    if (multi_press_err) errn++;
    if (32'(vote_candidate_1) + 32'(vote_candidate_2) + 32'(vote_candidate_3) > 1) dual_vote = 1'b1;
  end

  function automatic logic [6:0] outs();
    return {candidate_ready, vote_candidate_1, vote_candidate_2, vote_candidate_3,
            ballot_lamp, buzzer, multi_press_err};
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0: return candidate_ready;
      1: return ballot_lamp;
      2: return buzzer;
      3: return vote_candidate_1;
      4: return vote_candidate_2;
      5: return vote_candidate_3;
      default: return multi_press_err;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles (negedges) until the selected output is seen high; returns limit on timeout.
  task automatic wait_sig(input int which, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sig(which) && cyc < limit);
  endtask

  // From LOCKED with the release debounced low: issue a ballot and let the release settle.
  task automatic open_ballot();
    int c;
    voting_in_progress = 1'b1;
    btn_release_raw = 1'b1;
    wait_sig(1, 40, c);
    btn_release_raw = 1'b0;
    checks++;
    if (ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL open_ballot: lamp=%b after %0d cycles, required 1", ballot_lamp, c);
    end
    step(22);
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: outs=%b, required 0000000", outs());
    end
    rst = 1'b1;
    step(2);
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL post_reset_idle: outs=%b, required 0000000", outs());
    end
  endtask

  task automatic test_release_arm();
    int c;
    voting_in_progress = 1'b0;
    btn_release_raw = 1'b1;
    wait_sig(0, 60, c);
    checks++;
    if (c !== 20) begin
      errors++;
      $display("FAIL ready_latency: %0d cycles, required 20", c);
    end
    step(3);
    checks++;
    if (candidate_ready !== 1'b1 || ballot_lamp !== 1'b0) begin
      errors++;
      $display("FAIL ready_held: ready=%b lamp=%b, required 1/0", candidate_ready, ballot_lamp);
    end
    voting_in_progress = 1'b1;
    step(1);
    checks++;
    if (candidate_ready !== 1'b0 || ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL ready_to_open: ready=%b lamp=%b, required 0/1", candidate_ready, ballot_lamp);
    end
    step(16);
    btn_release_raw = 1'b0;
    step(22);
    voting_in_progress = 1'b0;
    step(1);
    checks++;
    if (ballot_lamp !== 1'b0) begin
      errors++;
      $display("FAIL evm_timeout_close: lamp=%b, required 0", ballot_lamp);
    end
  endtask

  task automatic test_vote_held();
    int c, nb, v2s;
    logic ready_seen;
    open_ballot();
    v2s = v2n;
    btn_c2_raw = 1'b1;
    wait_sig(4, 40, c);
    checks++;
    if (c !== 20 || ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL vote2_latency: %0d cycles lamp=%b, required 20/1", c, ballot_lamp);
    end
    step(1);
    checks++;
    if (vote_candidate_2 !== 1'b0 || buzzer !== 1'b1 || ballot_lamp !== 1'b0) begin
      errors++;
      $display("FAIL vote2_to_beep: vote2=%b buzz=%b lamp=%b, required 0/1/0",
               vote_candidate_2, buzzer, ballot_lamp);
    end
    nb = 0;
    while (buzzer && nb < 20) begin
      nb++;
      step(1);
    end
    checks++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL buzz_length: %0d cycles, required 8", nb);
    end
    // Release pressed while the candidate button is still held must be ignored.
    ready_seen = 1'b0;
    btn_release_raw = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (candidate_ready) ready_seen = 1'b1;
    end
    btn_release_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (candidate_ready) ready_seen = 1'b1;
    end
    btn_c2_raw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (candidate_ready) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("FAIL wait_rel_blocks_release: ready seen=%b, required 0", ready_seen);
    end
    checks++;
    if (v2n - v2s !== 1) begin
      errors++;
      $display("FAIL vote2_count: %0d pulses, required 1", v2n - v2s);
    end
  endtask

  task automatic test_bounce();
    int c, v2s, es;
    open_ballot();
    v2s = v2n;
    es = errn;
    for (int k = 0; k < 20; k++) begin
      btn_c2_raw = ((k / 3) % 2 == 0);
      step(1);
    end
    btn_c2_raw = 1'b1;
    // Raw has been steadily high since cycle 18 of the bounce pattern.
    wait_sig(4, 40, c);
    checks++;
    if (c !== 18) begin
      errors++;
      $display("FAIL bounce_latency: %0d cycles, required 18", c);
    end
    btn_c2_raw = 1'b0;
    step(60);
    checks++;
    if (v2n - v2s !== 1 || errn - es !== 0) begin
      errors++;
      $display("FAIL bounce_counts: votes=%0d errs=%0d, required 1/0", v2n - v2s, errn - es);
    end
  endtask

  task automatic test_multi_press();
    int c, v1s, v2s, v3s, es;
    open_ballot();
    v1s = v1n; v2s = v2n; v3s = v3n; es = errn;
    btn_c1_raw = 1'b1;
    btn_c3_raw = 1'b1;
    wait_sig(6, 40, c);
    checks++;
    if (c !== 20) begin
      errors++;
      $display("FAIL multi_err_latency: %0d cycles, required 20", c);
    end
    step(10);
    btn_c1_raw = 1'b0;
    btn_c3_raw = 1'b0;
    step(25);
    checks++;
    if (errn - es !== 1 || v1n - v1s !== 0 || v2n - v2s !== 0 || v3n - v3s !== 0 || ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL multi_reject: errs=%0d votes=%0d/%0d/%0d lamp=%b, required 1 0/0/0 1",
               errn - es, v1n - v1s, v2n - v2s, v3n - v3s, ballot_lamp);
    end
    btn_c3_raw = 1'b1;
    wait_sig(5, 40, c);
    checks++;
    if (c !== 20) begin
      errors++;
      $display("FAIL lone_c3_latency: %0d cycles, required 20", c);
    end
    btn_c3_raw = 1'b0;
    step(60);
    checks++;
    if (v3n - v3s !== 1 || v1n - v1s !== 0) begin
      errors++;
      $display("FAIL lone_c3_count: v3=%0d v1=%0d, required 1/0", v3n - v3s, v1n - v1s);
    end
  endtask

  task automatic test_arm_timeout();
    int c, n;
    voting_in_progress = 1'b0;
    btn_release_raw = 1'b1;
    wait_sig(0, 60, c);
    btn_release_raw = 1'b0;
    n = 0;
    while (candidate_ready && n < 150) begin
      n++;
      step(1);
    end
    checks++;
    if (c !== 20 || n !== 100) begin
      errors++;
      $display("FAIL arm_timeout: latency=%0d high=%0d, required 20/100", c, n);
    end
    checks++;
    if (ballot_lamp !== 1'b0 || candidate_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_locked: lamp=%b ready=%b, required 0/0", ballot_lamp, candidate_ready);
    end
    btn_release_raw = 1'b1;
    wait_sig(0, 60, c);
    voting_in_progress = 1'b1;
    step(1);
    checks++;
    if (c !== 20 || candidate_ready !== 1'b0 || ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL second_release: latency=%0d ready=%b lamp=%b, required 20/0/1",
               c, candidate_ready, ballot_lamp);
    end
    btn_release_raw = 1'b0;
    step(22);
  endtask

  task automatic test_power_off();
    // Entered with a ballot already open from the previous task.
    checks++;
    if (ballot_lamp !== 1'b1) begin
      errors++;
      $display("FAIL power_pre_open: lamp=%b, required 1", ballot_lamp);
    end
    switch_on_evm = 1'b0;
    step(1);
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL power_off_outputs: outs=%b, required 0000000", outs());
    end
    switch_on_evm = 1'b1;
    step(3);
    checks++;
    if (ballot_lamp !== 1'b0 || candidate_ready !== 1'b0) begin
      errors++;
      $display("FAIL power_on_locked: lamp=%b ready=%b, required 0/0", ballot_lamp, candidate_ready);
    end
  endtask

  task automatic test_async_reset();
    open_ballot();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: outs=%b, required 0000000", outs());
    end
    step(1);
    rst = 1'b1;
    step(2);
    checks++;
    if (ballot_lamp !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked: lamp=%b, required 0", ballot_lamp);
    end
  endtask

`ifdef BALLOT_AUDIT_EN
  task automatic test_audit();
    int c;
    switch_on_evm = 1'b0;
    step(2);
    switch_on_evm = 1'b1;
    checks++;
    if (audit_ballots_issued !== 7'd0 || audit_votes_cast !== 7'd0) begin
      errors++;
      $display("FAIL audit_clear: %0d/%0d, required 0/0", audit_ballots_issued, audit_votes_cast);
    end
    for (int i = 0; i < 3; i++) begin
      open_ballot();
      btn_c1_raw = 1'b1;
      wait_sig(3, 40, c);
      btn_c1_raw = 1'b0;
      step(60);
    end
    checks++;
    if (audit_ballots_issued !== 7'd3 || audit_votes_cast !== 7'd3) begin
      errors++;
      $display("FAIL audit_counts: %0d/%0d, required 3/3", audit_ballots_issued, audit_votes_cast);
    end
    switch_on_evm = 1'b0;
    step(1);
    checks++;
    if (audit_ballots_issued !== 7'd0 || audit_votes_cast !== 7'd0) begin
      errors++;
      $display("FAIL audit_power_off: %0d/%0d, required 0/0", audit_ballots_issued, audit_votes_cast);
    end
    switch_on_evm = 1'b1;
    step(2);
  endtask
`endif

  task automatic test_exclusive();
    checks++;
    if (dual_vote !== 1'b0) begin
      errors++;
      $display("FAIL vote_exclusive: overlap=%b, required 0", dual_vote);
    end
  endtask

  initial begin
    test_reset();
    test_release_arm();
    test_vote_held();
    test_bounce();
    test_multi_press();
    test_arm_timeout();
    test_power_off();
    test_async_reset();
`ifdef BALLOT_AUDIT_EN
    test_audit();
`endif
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
